ir_key_event: RTL and testbench
===============================

IR_KEY_EVENT -- requirements
Module: ir_key_event

Interface
REQ-001 Parameter: HOLD_CYCLES, 6_000_000, key-hold window in clocks (120 ms at 50 MHz).
REQ-002 Parameter: ADDR_MATCH, 8'h00, accepted remote address when address filtering is compiled in.
REQ-003 Port: CLK_50M  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: ir_data  in  32  decoded NEC frame from the IR decoder: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
REQ-006 Port: ir_stb  in  1  one-cycle pulse, ir_data valid in that cycle.
REQ-007 Port: evt_valid  out  1  event FIFO head valid.
REQ-008 Port: evt_ready  in  1  consumer (LCD display stage) accepts head.
REQ-009 Port: evt_data  out  17  {repeat, addr[7:0], cmd[7:0]} of FIFO head.
REQ-010 Port: key_down  out  1  high while a key is held (HELD state).
REQ-011 Port: key_release  out  1  one-cycle pulse on hold-window expiry.
REQ-012 Port: err_cnt  out  8  count of rejected frames, saturating at 8'hFF.
REQ-013 Port: ovf  out  1  sticky: an event was dropped on a full FIFO.
REQ-014 Port: clr  in  1  one-cycle pulse clearing err_cnt and ovf.

Function
REQ-015 Cycle N ir_stb sampled: ir_data registered into check stage; check result acts at edge N+1.
REQ-016 Frame valid only if ir_data[31:24] == ~ir_data[23:16]; else dropped, err_cnt += 1 (saturating), FSM and timer unaffected.
REQ-017 FSM states IDLE, HELD; reset state IDLE; key_down = (state == HELD).
REQ-018 IDLE + valid frame: push {0,addr,cmd}, load timer with HOLD_CYCLES-1, go HELD.
REQ-019 HELD + valid frame with same {addr,cmd} as last pushed key: push {1,addr,cmd}, reload timer.
REQ-020 HELD + valid frame with different {addr,cmd}: push {0,addr,cmd}, reload timer, stay HELD.
REQ-021 HELD, no valid frame: timer decrements; at 0 go IDLE and pulse key_release for exactly one cycle.
REQ-022 Timer reaching 0 in the same cycle as a valid frame: the frame wins, handled per REQ-019/020, no key_release.
REQ-023 Event FIFO: depth 4, first-word fall-through; pushed event visible on evt_data with evt_valid=1 in the cycle after the push edge (ir_stb to evt_valid latency 2 clocks when empty).
REQ-024 Pop when evt_valid && evt_ready at the rising edge; evt_data held stable while evt_valid && !evt_ready.
REQ-025 Push into full FIFO without simultaneous pop: event dropped, ovf set; FSM/timer still update.
REQ-026 Push and pop in the same cycle on a full FIFO: both succeed, occupancy stays 4, ovf unchanged.
REQ-027 Push and pop in the same cycle on an empty FIFO: impossible by construction (evt_valid=0); push alone takes effect.
REQ-028 FIFO pointers 2-bit, wrap modulo 4; occupancy 3-bit 0..4.
REQ-029 clr: err_cnt <= 0, ovf <= 0 next edge; clr and error in same cycle -> err_cnt = 1; clr does not touch FIFO or FSM.

Reset
REQ-030 rst: state IDLE, timer 0, FIFO empty (pointers 0), evt_valid 0, evt_data 0, key_down 0, key_release 0, err_cnt 0, ovf 0, check stage cleared.
REQ-031 rst mid-hold or with FIFO occupied: all state discarded, no key_release pulse; rst overrides ir_stb and clr.

Configuration
REQ-032 Macro IR_ADDR_FILTER_EN defined: frame also requires ir_data[15:8] == ~ir_data[7:0]; a frame that passes both checks but has addr != ADDR_MATCH is dropped silently (no err_cnt change, no FSM effect).
REQ-033 Macro IR_ADDR_FILTER_EN undefined: address bytes unchecked; every frame passing REQ-016 is accepted.

Verification
REQ-034 Reset, ir_data=32'hBF40FF00 pulse -> 2 clocks later evt_valid=1, evt_data=17'h0_00_40, key_down=1.
REQ-035 Same frame re-sent every 108 ms x3, then silence -> events repeat=1 x3, key_release one pulse 120 ms after last frame, key_down=0.
REQ-036 ir_data=32'hBE40FF00 (cmd complement bad) -> no event, err_cnt=1; 300 bad frames -> err_cnt=8'hFF; clr -> 0.
REQ-037 evt_ready=0, 5 distinct valid frames -> 4 events held in order, ovf=1; then evt_ready=1 -> 4 pops in order, evt_valid=0.
REQ-038 With IR_ADDR_FILTER_EN, ADDR_MATCH=8'h00, frame 32'hBF40FE01 -> dropped, err_cnt unchanged; without macro -> event 17'h0_01_40.
REQ-039 rst asserted during HELD with 2 queued events -> next cycle evt_valid=0, key_down=0, no key_release.

Source files
------------

// File: rtl/ir_key_event.sv
// rtl/ir_key_event.sv - NEC key-event tracker: frame check, hold timer FSM, 4-deep FWFT event FIFO
// Optional macro IR_ADDR_FILTER_EN: also check address complement and accept only ADDR_MATCH.
module ir_key_event #(
  parameter int unsigned HOLD_CYCLES = 6_000_000,
  parameter logic [7:0]  ADDR_MATCH  = 8'h00
) (
  input  logic        CLK_50M,
  input  logic        rst,
  input  logic [31:0] ir_data,
  input  logic        ir_stb,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [16:0] evt_data,
  output logic        key_down,
  output logic        key_release,
  output logic [7:0]  err_cnt,
  output logic        ovf,
  input  logic        clr
);

  localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HELD} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [15:0]   last_key;
  logic          chk_vld;
  logic [31:0]   chk_data;
  logic [16:0]   mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;

  logic [7:0]  f_addr;
  logic [7:0]  f_cmd;
  logic        frame_bad;
  logic        frame_take;
  logic        is_rep;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;

  assign f_addr = chk_data[7:0];
  assign f_cmd  = chk_data[23:16];

`ifdef IR_ADDR_FILTER_EN
  always_comb begin
    frame_bad  = chk_vld && ((chk_data[31:24] != ~f_cmd) || (chk_data[15:8] != ~f_addr));
    frame_take = chk_vld && !frame_bad && (f_addr == ADDR_MATCH);
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{chk_data[15:8], ADDR_MATCH};

  always_comb begin
    frame_bad  = chk_vld && (chk_data[31:24] != ~f_cmd);
    frame_take = chk_vld && !frame_bad;
  end
`endif

  assign is_rep    = (state == HELD) && ({f_addr, f_cmd} == last_key);
  assign evt_valid = (count != 3'd0);
  assign evt_data  = mem[rd_ptr];
  assign key_down  = (state == HELD);
  assign pop       = evt_valid && evt_ready;
  assign full      = (count == 3'd4);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push_ok   = frame_take && (!full || pop);
  assign drop      = frame_take && full && !pop;

  always_ff @(posedge CLK_50M) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      last_key    <= '0;
      chk_vld     <= 1'b0;
      chk_data    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      key_release <= 1'b0;
      err_cnt     <= '0;
      ovf         <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      chk_vld     <= ir_stb;
      chk_data    <= ir_stb ? ir_data : chk_data;
      key_release <= 1'b0;

      // A valid frame outranks expiry on the same edge.
      if (frame_take) begin
        state    <= HELD;
        timer    <= TW'(HOLD_CYCLES - 1);
        last_key <= {f_addr, f_cmd};
      end else if (state == HELD) begin
        if (timer == '0) begin
          state       <= IDLE;
          key_release <= 1'b1;
        end else begin
          timer <= timer - TW'(1);
        end
      end

      if (push_ok) begin
        mem[wr_ptr] <= {is_rep, f_addr, f_cmd};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;

      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (clr)                                err_cnt <= {7'd0, frame_bad};
      else if (frame_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (clr)       ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_key_event.sv
// tb/tb_ir_key_event.sv - directed + randomized bench for ir_key_event against an elapsed-time event model
module tb_ir_key_event;

  localparam int         HOLD = 20;
  localparam logic [7:0] AM   = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_stb = 1'b0;
  logic        evt_ready = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] ir_data = '0;
  logic        evt_valid;
  logic [16:0] evt_data;
  logic        key_down;
  logic        key_release;
  logic [7:0]  err_cnt;
  logic        ovf;

  ir_key_event #(.HOLD_CYCLES(HOLD), .ADDR_MATCH(AM)) dut (
    .CLK_50M(clk), .rst(rst), .ir_data(ir_data), .ir_stb(ir_stb),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .key_down(key_down), .key_release(key_release), .err_cnt(err_cnt),
    .ovf(ovf), .clr(clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: event list, held flag and time of the last accepted key.
  logic [16:0] q[$];
  bit          m_held, m_rel, m_ovf, m_pv;
  logic [7:0]  m_err;
  logic [15:0] m_last;
  logic [31:0] m_pend;
  int          cyc = 0;
  int          m_t = 0;
  int          rel_seen = 0;
  int          rep_seen = 0;

  function automatic logic [31:0] frame(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic [31:0] d, input logic rd, input logic c, input logic r);
    logic [7:0] a, cm;
    bit bad, take, pop, drop;
    cyc++;
    m_rel = 0;
    if (r) begin
      q.delete(); m_held = 0; m_ovf = 0; m_err = 0; m_pv = 0;
      return;
    end
    pop  = (q.size() != 0) && rd;
    a    = m_pend[7:0];
    cm   = m_pend[23:16];
    bad  = 0;
    take = 0;
    drop = 0;
    if (m_pv) begin
      if (m_pend[31:24] != ~cm) bad = 1;
`ifdef IR_ADDR_FILTER_EN
      else if (m_pend[15:8] != ~a) bad = 1;
      else if (a == AM) take = 1;
`else
      else take = 1;
`endif
    end
    if (c) m_err = bad ? 8'd1 : 8'd0;
    else if (bad && m_err != 8'hFF) m_err++;
    if (pop) void'(q.pop_front());
    if (take) begin
      if (q.size() == 4) drop = 1;
      else q.push_back({m_held && ({a, cm} == m_last), a, cm});
      m_held = 1;
      m_last = {a, cm};
      m_t    = cyc;
    end else if (m_held && (cyc - m_t == HOLD)) begin
      m_held = 0;
      m_rel  = 1;
    end
    if (c) m_ovf = 0;
    else if (drop) m_ovf = 1;
    m_pv   = s;
    m_pend = d;
  endtask

  task automatic step(input logic s, input logic [31:0] d, input logic rd, input logic c, input logic r);
    @(negedge clk);
    ir_stb = s; ir_data = d; evt_ready = rd; clr = c; rst = r;
    @(posedge clk);
    model_edge(s, d, rd, c, r);
    #1;
    chk("evt_valid", evt_valid, q.size() != 0);
    if (q.size() != 0) chk("evt_data", evt_data, q[0]);
    chk("key_down", key_down, m_held);
    chk("key_release", key_release, m_rel);
    chk("err_cnt", err_cnt, m_err);
    chk("ovf", ovf, m_ovf);
    if (key_release) rel_seen++;
    if (evt_valid && evt_ready && evt_data[16]) rep_seen++;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rd, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_data", evt_data, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // First press: event two clocks after the strobe
    step(1'b1, 32'hBF40FF00, 1'b0, 1'b0, 1'b0);
    chk("lat1_evt_valid", evt_valid, 0);
    idle(1, 1'b0);
    chk("press_evt_valid", evt_valid, 1);
    chk("press_evt_data", evt_data, 17'h0_00_40);
    chk("press_key_down", key_down, 1);

    // Repeats every 18 clocks, then silence until release
    rel_seen = 0; rep_seen = 0;
    idle(14, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'hBF40FF00, 1'b1, 1'b0, 1'b0);
      idle(17, 1'b1);
      chk("rep_key_down", key_down, 1);
    end
    idle(10, 1'b1);
    chk("rep_count", rep_seen, 3);
    chk("release_count", rel_seen, 1);
    chk("release_key_down", key_down, 0);

    // Bad command complement, saturation, clear
    step(1'b1, 32'hBE40FF00, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("bad_no_event", evt_valid, 0);
    chk("bad_err1", err_cnt, 1);
    for (int k = 0; k < 300; k++) step(1'b1, 32'hBE40FF00, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("err_sat", err_cnt, 8'hFF);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("err_clr", err_cnt, 0);
    step(1'b1, 32'hBE40FF00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("clr_with_err", err_cnt, 1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Overflow: five distinct keys with the consumer stalled
    for (int k = 0; k < 5; k++) begin
      step(1'b1, frame(8'h00, 8'h10 + 8'(k)), 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
    end
    chk("ovf_set", ovf, 1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order_valid", evt_valid, 1);
      chk("ovf_order_data", evt_data, {1'b0, 8'h00, 8'h10 + 8'(k)});
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("drained", evt_valid, 0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Address byte handling
    step(1'b1, 32'hBF40FE01, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
`ifdef IR_ADDR_FILTER_EN
    chk("addr_filtered", evt_valid, 0);
    chk("addr_err_same", err_cnt, 0);
`else
    chk("addr_accept_valid", evt_valid, 1);
    chk("addr_accept_data", evt_data, 17'h0_01_40);
`endif
    idle(2, 1'b1);

    // Reset while held with two queued events
    step(1'b1, frame(8'h00, 8'h31), 1'b0, 1'b0, 1'b0);
    step(1'b1, frame(8'h00, 8'h32), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("pre_rst_down", key_down, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_hold_valid", evt_valid, 0);
    chk("rst_hold_down", key_down, 0);
    chk("rst_hold_rel", key_release, 0);
    rel_seen = 0;
    idle(HOLD + 5, 1'b0);
    chk("rst_no_release", rel_seen, 0);

    // Randomized traffic, alternating dense and sparse strobes
    for (int i = 0; i < 4000; i++) begin
      logic [7:0]  a, c;
      logic [31:0] fr;
      int          sel;
      logic        s;
      sel = $urandom_range(0, 99);
      a   = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
      c   = 8'h20 + 8'($urandom_range(0, 2));
      fr  = frame(a, c);
      if (sel < 12) fr[31:24] = fr[31:24] ^ 8'h5A;
      else if (sel < 18) fr[15:8] = fr[15:8] ^ 8'h0F;
      if (((i / 250) % 2) == 0) s = ($urandom_range(0, 3) == 0);
      else                      s = ($urandom_range(0, 39) == 0);
      step(s, fr, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 599) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
